// File: rtl/arf156b040e2r2w0cbbehbaa4acw_wr_stage_if.sv
// Purpose: two-port write-request bus into the latch register file write stage.
// Latency: none, wires only.
// Backpressure: wr_rdy is driven by the stage; the master holds a request until wr_rdy=1.
interface arf156b040e2r2w0cbbehbaa4acw_wr_stage_if #(
  parameter int AW    = 8,
  parameter int WIDTH = 40
) ();
  logic             wr0_en;
  logic [AW-1:0]    wr0_addr;
  logic [WIDTH-1:0] wr0_data;
  logic             wr1_en;
  logic [AW-1:0]    wr1_addr;
  logic [WIDTH-1:0] wr1_data;
  logic             wr_rdy;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    input  wr_rdy
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    output wr_rdy
  );
endinterface

// File: rtl/arf156b040e2r2w0cbbehbaa4acw_wr_stage.sv
// Purpose: stage both write ports, decode to one-hot word-lines, resolve collisions, drop out-of-range.
// Latency: request accepted at edge N drives wl/wd during cycle N..N+1.
// Backpressure: stall freezes the stage and blanks word-lines; wr_rdy = ~stall.
module arf156b040e2r2w0cbbehbaa4acw_wr_stage #(
  parameter int ENTRIES = 156,
  parameter int WIDTH   = 40,
  parameter int AW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  arf156b040e2r2w0cbbehbaa4acw_wr_stage_if.slave i_wr,
  output logic [ENTRIES-1:0]   o_wl0,
  output logic [WIDTH-1:0]     o_wd0,
  output logic [ENTRIES-1:0]   o_wl1,
  output logic [WIDTH-1:0]     o_wd1,
  output logic                 o_collide,
  output logic                 o_oob_err,
  output logic [7:0]           o_oob_cnt,
  output logic [15:0]          o_wr_cnt
);
  localparam logic [AW:0] LP_ENT = (AW+1)'(ENTRIES);

  logic               r_vld0, r_vld1;
  logic [ENTRIES-1:0] r_wl0, r_wl1;
  logic [WIDTH-1:0]   r_wd0, r_wd1;
  logic               r_collide;
  logic               r_oob_err;
  logic [7:0]         r_oob_cnt;
  logic [15:0]        r_wr_cnt;

  logic               w_inr0, w_inr1, w_oob0, w_oob1, w_col;
  logic               w_take0;
  logic [ENTRIES-1:0] w_dec0, w_dec1;
  logic [1:0]         w_oob_inc;
  logic [8:0]         w_oob_sum;
  logic [15:0]        w_wr_inc;

  // Request classification, collision detect and one-hot decode.
  always_comb begin
    w_inr0    = i_wr.wr0_en && ({1'b0, i_wr.wr0_addr} < LP_ENT);
    w_inr1    = i_wr.wr1_en && ({1'b0, i_wr.wr1_addr} < LP_ENT);
    w_oob0    = i_wr.wr0_en && !w_inr0;
    w_oob1    = i_wr.wr1_en && !w_inr1;
    // Port 1 wins a same-entry collision, so port 0 is the one squashed.
    w_col     = w_inr0 && w_inr1 && (i_wr.wr0_addr == i_wr.wr1_addr);
    w_take0   = w_inr0 && !w_col;
    w_dec0    = {{(ENTRIES-1){1'b0}}, 1'b1} << i_wr.wr0_addr;
    w_dec1    = {{(ENTRIES-1){1'b0}}, 1'b1} << i_wr.wr1_addr;
    w_oob_inc = {1'b0, w_oob0} + {1'b0, w_oob1};
    w_oob_sum = {1'b0, r_oob_cnt} + {7'b0, w_oob_inc};
    w_wr_inc  = {15'b0, r_vld0} + {15'b0, r_vld1};
  end

  // S1 stage register: reload on every unstalled edge, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld0    <= 1'b0;
      r_vld1    <= 1'b0;
      r_wl0     <= '0;
      r_wl1     <= '0;
      r_wd0     <= '0;
      r_wd1     <= '0;
      r_collide <= 1'b0;
    end else if (!i_stall) begin
      r_vld0    <= w_take0;
      r_vld1    <= w_inr1;
      r_wl0     <= w_take0 ? w_dec0 : '0;
      r_wl1     <= w_inr1  ? w_dec1 : '0;
      r_collide <= w_col;
      if (w_inr0) r_wd0 <= i_wr.wr0_data;
      if (w_inr1) r_wd1 <= i_wr.wr1_data;
    end
  end

  // Status counters: wr_cnt counts word-lines just presented, oob counts at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oob_err <= 1'b0;
      r_oob_cnt <= '0;
      r_wr_cnt  <= '0;
    end else if (!i_stall) begin
      r_wr_cnt <= r_wr_cnt + w_wr_inc;
      if (w_oob0 || w_oob1) begin
        r_oob_err <= 1'b1;
        r_oob_cnt <= w_oob_sum[8] ? 8'hFF : w_oob_sum[7:0];
      end
    end
  end

  // Output drive: word-lines and collide blanked while the array is busy.
  always_comb begin
    i_wr.wr_rdy = !i_stall;
    o_wl0       = r_wl0 & {ENTRIES{!i_stall}};
    o_wl1       = r_wl1 & {ENTRIES{!i_stall}};
    o_wd0       = r_wd0;
    o_wd1       = r_wd1;
    o_collide   = r_collide && !i_stall;
    o_oob_err   = r_oob_err;
    o_oob_cnt   = r_oob_cnt;
    o_wr_cnt    = r_wr_cnt;
  end
endmodule

// File: tb/tb_arf156b040e2r2w0cbbehbaa4acw_wr_stage.sv
module tb_arf156b040e2r2w0cbbehbaa4acw_wr_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         e0 = 1'b0, e1 = 1'b0;
  logic [7:0]   a0 = '0, a1 = '0;
  logic [39:0]  d0 = '0, d1 = '0;
  logic [155:0] wl0, wl1;
  logic [39:0]  wd0, wd1;
  logic         collide, oob_err;
  logic [7:0]   oob_cnt;
  logic [15:0]  wr_cnt;

  int n_chk = 0;
  int n_err = 0;

  arf156b040e2r2w0cbbehbaa4acw_wr_stage_if #(.AW(8), .WIDTH(40)) wif ();
  assign wif.wr0_en   = e0;
  assign wif.wr0_addr = a0;
  assign wif.wr0_data = d0;
  assign wif.wr1_en   = e1;
  assign wif.wr1_addr = a1;
  assign wif.wr1_data = d1;

  arf156b040e2r2w0cbbehbaa4acw_wr_stage #(.ENTRIES(156), .WIDTH(40), .AW(8)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_wr(wif.slave),
    .o_wl0(wl0), .o_wd0(wd0), .o_wl1(wl1), .o_wd1(wd1),
    .o_collide(collide), .o_oob_err(oob_err), .o_oob_cnt(oob_cnt), .o_wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [155:0] oh(input int a);
    logic [155:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Behavioural model: what the array must currently see, in terms of entry indices.
  bit          m_v0, m_v1, m_col, m_oerr;
  int          m_a0, m_a1, m_ocnt, m_wcnt;
  logic [39:0] m_d0, m_d1;

  always @(posedge clk) begin
    bit in0, in1, c;
    int drop;
    if (rst) begin
      m_v0 = 0; m_v1 = 0; m_col = 0; m_oerr = 0; m_ocnt = 0; m_wcnt = 0;
    end else if (!stall) begin
      m_wcnt = (m_wcnt + int'(m_v0) + int'(m_v1)) % 65536;
      in0  = e0 && (int'(a0) < 156);
      in1  = e1 && (int'(a1) < 156);
      drop = int'(e0 && !in0) + int'(e1 && !in1);
      if (drop > 0) m_oerr = 1;
      m_ocnt = (m_ocnt + drop > 255) ? 255 : m_ocnt + drop;
      c = in0 && in1 && (a0 == a1);
      m_v0 = in0 && !c;  m_a0 = int'(a0);  m_d0 = d0;
      m_v1 = in1;        m_a1 = int'(a1);  m_d1 = d1;
      m_col = c;
    end
  end

  // Per-cycle compare against the model, half a cycle away from the edge.
  always @(negedge clk) begin
    chk("m_wl0", wl0, (m_v0 && !stall) ? oh(m_a0) : '0);
    chk("m_wl1", wl1, (m_v1 && !stall) ? oh(m_a1) : '0);
    if (m_v0) chk("m_wd0", wd0, m_d0);
    if (m_v1) chk("m_wd1", wd1, m_d1);
    chk("m_collide", collide, m_col && !stall);
    chk("m_wr_rdy", wif.wr_rdy, !stall);
    chk("m_oob_err", oob_err, m_oerr);
    chk("m_oob_cnt", oob_cnt, m_ocnt[7:0]);
    chk("m_wr_cnt", wr_cnt, m_wcnt[15:0]);
  end

  task automatic drive(input logic st, input logic en0, input int ad0, input logic [39:0] dt0,
                       input logic en1, input int ad1, input logic [39:0] dt1);
    stall = st;
    e0 = en0; a0 = ad0[7:0]; d0 = dt0;
    e1 = en1; a1 = ad1[7:0]; d1 = dt1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, '0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wl0", wl0, '0);
    chk("rst_wl1", wl1, '0);
    chk("rst_wd0", wd0, '0);
    chk("rst_collide", collide, 1'b0);
    chk("rst_oob_err", oob_err, 1'b0);
    chk("rst_wr_cnt", wr_cnt, 16'd0);

    // Two independent writes.
    drive(0, 1, 5, 40'h12_3456_789A, 1, 155, 40'hFF_0000_0001);
    tick();
    drive(0, 0, 0, '0, 0, 0, '0);
    chk("t1_wl0", wl0, 156'h1 << 5);
    chk("t1_wl1", wl1, 156'h1 << 155);
    chk("t1_wd0", wd0, 40'h12_3456_789A);
    chk("t1_wd1", wd1, 40'hFF_0000_0001);
    tick();
    chk("t1_idle_wl0", wl0, '0);
    chk("t1_wr_cnt", wr_cnt, 16'd2);

    // Collision on entry 42: port 1 wins.
    drive(0, 1, 42, 40'hAA_AAAA_AAAA, 1, 42, 40'hBB_BBBB_BBBB);
    tick();
    drive(0, 0, 0, '0, 0, 0, '0);
    chk("t2_wl0", wl0, '0);
    chk("t2_wl1", wl1, 156'h1 << 42);
    chk("t2_wd1", wd1, 40'hBB_BBBB_BBBB);
    chk("t2_collide", collide, 1'b1);
    tick();
    chk("t2_collide_drop", collide, 1'b0);
    chk("t2_wr_cnt", wr_cnt, 16'd3);

    // Out-of-range on both ports, then saturation.
    drive(0, 1, 156, 40'h1, 1, 200, 40'h2);
    tick();
    drive(0, 0, 0, '0, 0, 0, '0);
    chk("t3_wl0", wl0, '0);
    chk("t3_wl1", wl1, '0);
    chk("t3_oob_err", oob_err, 1'b1);
    chk("t3_oob_cnt", oob_cnt, 8'd2);
    for (int i = 0; i < 129; i++) begin
      drive(0, 1, 156, 40'h1, 1, 200, 40'h2);
      tick();
    end
    drive(0, 0, 0, '0, 0, 0, '0);
    tick();
    chk("t3_oob_sat", oob_cnt, 8'd255);
    chk("t3_oob_sticky", oob_err, 1'b1);
    chk("t3_wr_cnt", wr_cnt, 16'd3);

    // Capture then three stalled cycles with ignored requests.
    drive(0, 1, 7, 40'h00_0000_0777, 0, 0, '0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 9, 40'h99, 1, 11, 40'h11);
      #1;
      chk("t4_stall_wl0", wl0, '0);
      chk("t4_stall_wl1", wl1, '0);
      chk("t4_stall_rdy", wif.wr_rdy, 1'b0);
      tick();
    end
    drive(0, 0, 0, '0, 0, 0, '0);
    #1;
    chk("t4_late_wl0", wl0, 156'h1 << 7);
    chk("t4_late_wd0", wd0, 40'h00_0000_0777);
    chk("t4_late_wl1", wl1, '0);
    tick();
    chk("t4_once_wl0", wl0, '0);
    chk("t4_wr_cnt", wr_cnt, 16'd4);

    // Back-to-back full-rate writes.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, i * 3, 40'(i + 100), 1, 150 - i, 40'(i + 200));
      tick();
    end
    drive(0, 0, 0, '0, 0, 0, '0);
    tick();
    chk("t5_wr_cnt", wr_cnt, 16'd20);

    // Held write discarded by reset.
    drive(0, 1, 3, 40'h33, 0, 0, '0);
    tick();
    drive(1, 0, 0, '0, 0, 0, '0);
    rst = 1'b1;
    #1;
    chk("t6_held_wl0", wl0, '0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, '0, 0, 0, '0);
    #1;
    chk("t6_after_wl0", wl0, '0);
    tick();
    chk("t6_wr_cnt", wr_cnt, 16'd0);
    chk("t6_oob_err", oob_err, 1'b0);
    chk("t6_oob_cnt", oob_cnt, 8'd0);

    // Wrap of the word-line counter.
    for (int i = 0; i < 65536; i++) begin
      drive(0, 1, i % 156, 40'(i), 0, 0, '0);
      tick();
    end
    chk("t7_wr_cnt_max", wr_cnt, 16'hFFFF);
    drive(0, 0, 0, '0, 0, 0, '0);
    tick();
    chk("t7_wr_cnt_wrap", wr_cnt, 16'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
